// File: rtl/fx3_gpif_pkg.sv
// Shared definitions for the FX3 GPIF slave-FIFO receiver model:
// link data width, FSM state encoding, flag polarities and the ramp
// checker helper used by the optional DATA_CHECK_EN build.
package fx3_gpif_pkg;

   localparam int GPIF_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_STARTUP  = 2'd0,
      ST_FILLING  = 2'd1,
      ST_DRAINING = 2'd2
   } gpif_state_e;

   // nReady is active low: 1 until the emulated FX3 has booted
   localparam logic NREADY_NOT_READY = 1'b1;
   localparam logic NREADY_READY     = 1'b0;

   // th0Ready is inverted relative to the internal ready: 1 = not ready
   localparam logic TH0_NOT_READY = 1'b1;
   localparam logic TH0_READY     = 1'b0;

   // Watermark idle level (reset and STARTUP)
   localparam logic WM_CLEAR = 1'b0;

   // True when cur does not follow prev by exactly step (mod 2^16)
   function automatic logic ramp_step_error(
      input logic [GPIF_DATA_W-1:0] cur,
      input logic [GPIF_DATA_W-1:0] prev,
      input logic [GPIF_DATA_W-1:0] step
   );
      logic [GPIF_DATA_W-1:0] delta;
      delta = cur - prev;
      return (delta != step);
   endfunction

endpackage

// File: rtl/fx3_flag_delay.sv
// Parameterised-depth flag delay line emulating FX3 flag latency.
// DEPTH = 0 is a straight wire; otherwise q is d delayed DEPTH clocks and
// every stage loads RESET_VAL on reset.
module fx3_flag_delay #(
   parameter int   DEPTH     = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_clk_s;
         assign unused_clk_s = clock ^ reset;
         assign q = d;
      end else begin : g_shift
         logic [DEPTH-1:0] shift_q;
         logic [DEPTH-1:0] shift_d;

         // Shift the new flag sample into stage 0, older samples move up
         always_comb begin
            shift_d    = shift_q;
            shift_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
               shift_d[i] = shift_q[i-1];
            end
         end

         // Delay-line register with the flag's idle value on reset
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               shift_q <= {DEPTH{RESET_VAL}};
            end else begin
               shift_q <= shift_d;
            end
         end

         assign q = shift_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/fx3_gpif_receiver.sv
// FX3 end of the GPIF slave-FIFO link: consumes the FPGA's 16-bit write
// stream into an emulated thread-0 DMA buffer, emulates USB drain time,
// drives nReady/th0Ready/th0Watermark back and counts traffic and faults.
// Optional ramp checker on the data stream: define DATA_CHECK_EN.
module fx3_gpif_receiver
   import fx3_gpif_pkg::*;
#(
   parameter int BUFFER_WORDS    = 8192,
   parameter int WATERMARK_WORDS = 6,
   parameter int DRAIN_CYCLES    = 4096,
   parameter int FLAG_LATENCY    = 2,
   parameter int STARTUP_CYCLES  = 16,
   parameter int RAMP_STEP       = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [GPIF_DATA_W-1:0]       gpifData,
   input  logic                         nWrite,
   input  logic                         nShort,
   input  logic                         nError,
   output logic                         nReady,
   output logic                         th0Ready,
   output logic                         th0Watermark,
   output logic [$clog2(BUFFER_WORDS):0] bufferFill,
   output logic [31:0]                  wordCount,
   output logic [31:0]                  bufferCount,
   output logic [15:0]                  shortCount,
   output logic                         overflowError,
   output logic                         writerErrorSeen
`ifdef DATA_CHECK_EN
   ,
   output logic [15:0]                  dataErrorCount
`endif
);

   localparam int FILL_W = $clog2(BUFFER_WORDS) + 1;
   localparam int TMAX   = (STARTUP_CYCLES > DRAIN_CYCLES) ? STARTUP_CYCLES : DRAIN_CYCLES;
   localparam int TW     = $clog2(TMAX + 1);

   localparam logic [FILL_W-1:0] FILL_FULL    = FILL_W'(BUFFER_WORDS);
   localparam logic [FILL_W-1:0] FILL_LAST    = FILL_W'(BUFFER_WORDS - 1);
   localparam logic [FILL_W-1:0] WM_LEVEL     = FILL_W'(WATERMARK_WORDS);
   localparam logic [TW-1:0]     STARTUP_LAST = TW'(STARTUP_CYCLES - 1);
   localparam logic [TW-1:0]     DRAIN_LAST   = TW'(DRAIN_CYCLES - 1);

   gpif_state_e        state_q, state_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [31:0]        word_count_q, word_count_d;
   logic [31:0]        buffer_count_q, buffer_count_d;
   logic [15:0]        short_count_q, short_count_d;
   logic               overflow_q, overflow_d;
   logic               writer_err_q, writer_err_d;
   logic               nready_q, nready_d;

   logic [FILL_W-1:0]  free_s;
   logic               ready_int_s;
   logic               watermark_int_s;
   logic               accept_s;
   logic               th0_ready_raw_s;

   // Internal (undelayed) ready/watermark derived from state and fill
   always_comb begin
      free_s          = FILL_FULL - fill_q;
      ready_int_s     = 1'b0;
      watermark_int_s = WM_CLEAR;
      case (state_q)
         ST_FILLING: begin
            if (fill_q < FILL_FULL) begin
               ready_int_s = 1'b1;
            end else begin
               ready_int_s = 1'b0;
            end
            watermark_int_s = (free_s <= WM_LEVEL);
         end
         ST_DRAINING: begin
            ready_int_s     = 1'b0;
            watermark_int_s = 1'b1;
         end
         default: begin
            ready_int_s     = 1'b0;
            watermark_int_s = WM_CLEAR;
         end
      endcase
      accept_s        = ready_int_s & ~nWrite;
      th0_ready_raw_s = ready_int_s ? TH0_READY : TH0_NOT_READY;
   end

   // Next-state logic: startup timer, buffer fill/commit, drain timer, counters
   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      fill_d         = fill_q;
      word_count_d   = word_count_q;
      buffer_count_d = buffer_count_q;
      short_count_d  = short_count_q;
      nready_d       = nready_q;
      // A write the buffer cannot take is dropped and flagged
      overflow_d     = overflow_q | (~nWrite & ~ready_int_s);
      writer_err_d   = writer_err_q | ~nError;

      case (state_q)
         ST_STARTUP: begin
            if (timer_q == STARTUP_LAST) begin
               state_d  = ST_FILLING;
               timer_d  = {TW{1'b0}};
               nready_d = NREADY_READY;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_FILLING: begin
            if (accept_s) begin
               fill_d       = fill_q + FILL_W'(1);
               word_count_d = word_count_q + 32'd1;
            end else begin
               fill_d       = fill_q;
               word_count_d = word_count_q;
            end
            // A word that completes the buffer makes it a full commit even
            // if nShort is also low on the same clock
            if (accept_s && (fill_q == FILL_LAST)) begin
               buffer_count_d = buffer_count_q + 32'd1;
               state_d        = ST_DRAINING;
               timer_d        = {TW{1'b0}};
            end else if (!nShort) begin
               buffer_count_d = buffer_count_q + 32'd1;
               short_count_d  = short_count_q + 16'd1;
               state_d        = ST_DRAINING;
               timer_d        = {TW{1'b0}};
            end else begin
               state_d = ST_FILLING;
            end
         end
         ST_DRAINING: begin
            if (timer_q == DRAIN_LAST) begin
               state_d = ST_FILLING;
               timer_d = {TW{1'b0}};
               fill_d  = {FILL_W{1'b0}};
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = ST_STARTUP;
            timer_d = {TW{1'b0}};
            fill_d  = {FILL_W{1'b0}};
         end
      endcase
   end

   // Main state, counters and sticky fault flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_STARTUP;
         timer_q        <= {TW{1'b0}};
         fill_q         <= {FILL_W{1'b0}};
         word_count_q   <= 32'd0;
         buffer_count_q <= 32'd0;
         short_count_q  <= 16'd0;
         overflow_q     <= 1'b0;
         writer_err_q   <= 1'b0;
         nready_q       <= NREADY_NOT_READY;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         fill_q         <= fill_d;
         word_count_q   <= word_count_d;
         buffer_count_q <= buffer_count_d;
         short_count_q  <= short_count_d;
         overflow_q     <= overflow_d;
         writer_err_q   <= writer_err_d;
         nready_q       <= nready_d;
      end
   end

   fx3_flag_delay #(
      .DEPTH     (FLAG_LATENCY),
      .RESET_VAL (TH0_NOT_READY)
   ) u_th0_ready_delay (
      .clock (clock),
      .reset (reset),
      .d     (th0_ready_raw_s),
      .q     (th0Ready)
   );

   fx3_flag_delay #(
      .DEPTH     (FLAG_LATENCY),
      .RESET_VAL (WM_CLEAR)
   ) u_th0_wm_delay (
      .clock (clock),
      .reset (reset),
      .d     (watermark_int_s),
      .q     (th0Watermark)
   );

   assign nReady          = nready_q;
   assign bufferFill      = fill_q;
   assign wordCount       = word_count_q;
   assign bufferCount     = buffer_count_q;
   assign shortCount      = short_count_q;
   assign overflowError   = overflow_q;
   assign writerErrorSeen = writer_err_q;

`ifdef DATA_CHECK_EN
   localparam logic [GPIF_DATA_W-1:0] RAMP = GPIF_DATA_W'(RAMP_STEP);

   logic [GPIF_DATA_W-1:0] last_word_q, last_word_d;
   logic                   have_last_q, have_last_d;
   logic [15:0]            data_err_q, data_err_d;

   // Ramp check on every accepted word after the first since reset
   always_comb begin
      last_word_d = last_word_q;
      have_last_d = have_last_q;
      data_err_d  = data_err_q;
      if (accept_s) begin
         last_word_d = gpifData;
         have_last_d = 1'b1;
         if (have_last_q && ramp_step_error(gpifData, last_word_q, RAMP) &&
             (data_err_q != 16'hFFFF)) begin
            data_err_d = data_err_q + 16'd1;
         end else begin
            data_err_d = data_err_q;
         end
      end else begin
         last_word_d = last_word_q;
      end
   end

   // Ramp checker registers; the chain survives buffer commits
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_word_q <= {GPIF_DATA_W{1'b0}};
         have_last_q <= 1'b0;
         data_err_q  <= 16'd0;
      end else begin
         last_word_q <= last_word_d;
         have_last_q <= have_last_d;
         data_err_q  <= data_err_d;
      end
   end

   assign dataErrorCount = data_err_q;
`else
   logic unused_data_s;
   assign unused_data_s = ^gpifData;
`endif

endmodule

// File: tb/tb_fx3_gpif_receiver.sv
// Self-checking bench for fx3_gpif_receiver: directed bring-up sequences
// followed by randomized traffic, compared every clock against a
// transaction-level model of the FX3 buffer (edge-indexed timeline).
module tb_fx3_gpif_receiver;

   localparam int BW = 16;
   localparam int WM = 4;
   localparam int DR = 10;
   localparam int FL = 2;
   localparam int SU = 4;
   localparam int RS = 64;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] gpifData;
   logic        nWrite, nShort, nError;
   logic        nReady, th0Ready, th0Watermark;
   logic [4:0]  bufferFill;
   logic [31:0] wordCount, bufferCount;
   logic [15:0] shortCount;
   logic        overflowError, writerErrorSeen;
`ifdef DATA_CHECK_EN
   logic [15:0] dataErrorCount;
`endif

   always #10 clock = ~clock;

   fx3_gpif_receiver #(
      .BUFFER_WORDS    (BW),
      .WATERMARK_WORDS (WM),
      .DRAIN_CYCLES    (DR),
      .FLAG_LATENCY    (FL),
      .STARTUP_CYCLES  (SU),
      .RAMP_STEP       (RS)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .gpifData        (gpifData),
      .nWrite          (nWrite),
      .nShort          (nShort),
      .nError          (nError),
      .nReady          (nReady),
      .th0Ready        (th0Ready),
      .th0Watermark    (th0Watermark),
      .bufferFill      (bufferFill),
      .wordCount       (wordCount),
      .bufferCount     (bufferCount),
      .shortCount      (shortCount),
      .overflowError   (overflowError),
      .writerErrorSeen (writerErrorSeen)
`ifdef DATA_CHECK_EN
      ,
      .dataErrorCount  (dataErrorCount)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: e = rising edges since reset release; the buffer is
   // available to the writer from edge avail_edge on; commits push that
   // edge out by the drain time and the contents are dropped when it arrives.
   int          e;
   int          avail_edge;
   bit          pending_clear;
   int          m_fill;
   int unsigned m_words, m_bufs;
   logic [15:0] m_shorts;
   bit          m_ovf, m_werr, m_have;
   logic [15:0] m_last, m_derr;
   bit          hist_rdy [8192];
   bit          hist_wm  [8192];
   logic [15:0] ramp_data;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)", tag, act, exp, e, $time);
      end
   endtask

   task automatic model_reset();
      e             = 0;
      avail_edge    = SU + 1;
      pending_clear = 1'b0;
      m_fill        = 0;
      m_words       = 0;
      m_bufs        = 0;
      m_shorts      = 16'd0;
      m_ovf         = 1'b0;
      m_werr        = 1'b0;
      m_have        = 1'b0;
      m_last        = 16'd0;
      m_derr        = 16'd0;
   endtask

   task automatic commit(input bit is_short);
      m_bufs++;
      if (is_short) m_shorts = m_shorts + 16'd1;
      avail_edge    = e + DR + 1;
      pending_clear = 1'b1;
   endtask

   task automatic model_step(input bit nw, input bit ns, input bit ne, input logic [15:0] d);
      bit          open;
      logic [15:0] diff;
      e++;
      open = (e >= avail_edge);
      if (!ne) m_werr = 1'b1;
      if (!nw) begin
         if (open) begin
            m_fill++;
            m_words++;
            diff = d - m_last;
            if (m_have && diff != 16'(RS) && m_derr != 16'hFFFF) m_derr = m_derr + 16'd1;
            m_last = d;
            m_have = 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (open) begin
         if (m_fill == BW) commit(1'b0);
         else if (!ns) commit(1'b1);
      end
      if (pending_clear && (e + 1 >= avail_edge)) begin
         m_fill        = 0;
         pending_clear = 1'b0;
      end
      hist_rdy[e] = (e + 1 >= avail_edge);
      hist_wm[e]  = (e + 1 >= avail_edge) ? ((BW - m_fill) <= WM) : (e >= SU);
   endtask

   task automatic compare_all();
      int idx;
      bit exp_rdy, exp_wm;
      idx     = e - FL;
      exp_rdy = (idx >= 1) ? hist_rdy[idx] : 1'b0;
      exp_wm  = (idx >= 1) ? hist_wm[idx]  : 1'b0;
      check_value("nReady",          nReady,          (e >= SU) ? 32'd0 : 32'd1);
      check_value("th0Ready",        th0Ready,        exp_rdy ? 32'd0 : 32'd1);
      check_value("th0Watermark",    th0Watermark,    exp_wm);
      check_value("bufferFill",      bufferFill,      m_fill);
      check_value("wordCount",       wordCount,       m_words);
      check_value("bufferCount",     bufferCount,     m_bufs);
      check_value("shortCount",      shortCount,      m_shorts);
      check_value("overflowError",   overflowError,   m_ovf);
      check_value("writerErrorSeen", writerErrorSeen, m_werr);
`ifdef DATA_CHECK_EN
      check_value("dataErrorCount",  dataErrorCount,  m_derr);
`endif
   endtask

   task automatic cycle(input bit nw, input bit ns, input bit ne, input logic [15:0] d);
      nWrite   = nw;
      nShort   = ns;
      nError   = ne;
      gpifData = d;
      @(posedge clock);
      model_step(nw, ns, ne, d);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, 16'h0000);
   endtask

   task automatic do_reset(input int n);
      nWrite = 1'b1;
      nShort = 1'b1;
      nError = 1'b1;
      reset  = 1'b1;
      model_reset();
      #1;
      compare_all();
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         compare_all();
      end
      reset = 1'b0;
   endtask

   initial begin
      gpifData  = 16'h0000;
      ramp_data = 16'h0000;
      do_reset(3);

      // Bring-up: nReady after SU clocks, th0Ready follows with flag latency
      idle(SU + 3);

      // Full buffer then two words into the drain window
      for (int i = 0; i < BW + 2; i++) begin
         cycle(1'b0, 1'b1, 1'b1, ramp_data);
         ramp_data = ramp_data + 16'(RS);
      end
      idle(DR + 4);
      check_value("full_words", wordCount, 32'd16);
      check_value("full_bufs",  bufferCount, 32'd1);
      check_value("full_ovf",   overflowError, 32'd1);

      // Short commit on the fifth word
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, (i == 4) ? 1'b0 : 1'b1, 1'b1, ramp_data);
         ramp_data = ramp_data + 16'(RS);
      end
      check_value("short_fill", bufferFill, 32'd5);
      idle(DR + 2);
      check_value("short_bufs",   bufferCount, 32'd2);
      check_value("short_shorts", shortCount, 32'd1);
      check_value("short_words",  wordCount, 32'd21);

      // Empty short commit (zero-length packet), writer error pulse
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);
      idle(DR + 2);

      // Reset with a partial buffer
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b1, 16'(i));
      check_value("mid_fill", bufferFill, 32'd9);
      do_reset(2);
      check_value("rst_fill",   bufferFill, 32'd0);
      check_value("rst_nready", nReady, 32'd1);
      check_value("rst_words",  wordCount, 32'd0);

      // Ramp checker: only 0x00C1 breaks the +0x40 sequence
      idle(SU + 1);
      cycle(1'b0, 1'b1, 1'b1, 16'h0000);
      cycle(1'b0, 1'b1, 1'b1, 16'h0040);
      cycle(1'b0, 1'b1, 1'b1, 16'h0080);
      cycle(1'b0, 1'b1, 1'b1, 16'h00C1);
      cycle(1'b0, 1'b1, 1'b1, 16'h0101);
`ifdef DATA_CHECK_EN
      check_value("ramp_errs", dataErrorCount, 32'd1);
`endif
      ramp_data = 16'h0141;

      // Randomized traffic, with one reset in the middle
      for (int i = 0; i < 800; i++) begin
         bit nw, ns, ne;
         logic [15:0] d;
         if (i == 400) do_reset($urandom_range(1, 3));
         nw = ($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1;
         ns = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
         ne = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
         d  = ($urandom_range(0, 9) < 8) ? ramp_data : 16'($urandom);
         if (!nw) ramp_data = d + 16'(RS);
         cycle(nw, ns, ne, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
